pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 74, payload width (EX/MEM bundle: mem_to_reg 2, mem_read 1, mem_write 1, reg_write 1, alu_result 32, rs2_data 32, rd_addr 5).
REQ-002 Parameter CTRL_W, default 5, count of payload MSBs treated as side-effect control bits; legal range 0..DATA_W.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 flush  in  1  synchronous kill of all held entries.
REQ-007 in_valid  in  1  upstream holds a valid payload.
REQ-008 in_ready  out  1  stage can accept a payload this cycle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 out_valid  out  1  out_data is valid.
REQ-011 out_ready  in  1  downstream accepts out_data this cycle.
REQ-012 out_data  out  DATA_W  payload to the next stage.
REQ-013 stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Storage: two entries, main (drives out_data) and skid; occupancy is a three-state FSM: EMPTY, ONE (main only), TWO (main + skid).
REQ-015 in_ready is a register output equal to 1 in EMPTY and ONE and 0 in TWO; no combinational path from out_ready to in_ready.
REQ-016 out_valid is 1 in ONE and TWO and 0 in EMPTY, driven directly from state.
REQ-017 Accept = in_valid and in_ready; Send = out_valid and out_ready.
REQ-018 EMPTY: Accept loads main and moves to ONE; otherwise stays.
REQ-019 ONE: Accept with Send reloads main and stays ONE; Accept without Send loads skid and moves to TWO; Send without Accept moves to EMPTY.
REQ-020 TWO: Send moves skid into main and goes to ONE; no Accept is possible in TWO.
REQ-021 Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N when the stage was EMPTY or ONE with Send.
REQ-022 Ordering: payloads leave in acceptance order; none dropped or duplicated except by flush or rst.
REQ-023 out_data is held stable while out_valid=1 and out_ready=0.
REQ-024 Bubble rule: when out_valid=0, the top CTRL_W bits of out_data are 0; other bits are don't-care but must not be X after reset.
REQ-025 flush=1 at an edge forces EMPTY and in_ready=1, and clears control bits of both entries; a payload offered in the same cycle is discarded; flush overrides Accept and Send.
REQ-026 stall_cnt increments by 1 each cycle with out_valid=1 and out_ready=0, holds at all-ones, and is unaffected by flush.

Reset
REQ-027 While rst=1: state EMPTY, in_ready=1, out_valid=0, both entries all-zero, stall_cnt=0.
REQ-028 rst asserted mid-transfer discards all held payloads immediately, without waiting for a clock edge.
REQ-029 After rst deasserts, the first Accept occurs no earlier than the first rising edge.

Structure
REQ-030 Shared package holds the FSM state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the EX/MEM payload field offsets and widths.
REQ-031 Single module with no sub-modules; the stall counter is inline.
REQ-032 The block replaces the fixed EX/MEM latch; stall and flush are driven by the hazard unit.

Verification
REQ-033 Streaming: out_ready=1; in_data=0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each; in_ready stays 1.
REQ-034 Backpressure: in ONE holding A, out_ready=0, offer B -> TWO, in_ready=0; raise out_ready -> A then B out; stall_cnt counts exact stall cycles.
REQ-035 Flush in TWO with in_valid=1 offering C -> next cycle out_valid=0, control bits 0, in_ready=1; C never appears.
REQ-036 Async reset: assert rst between edges in TWO -> out_valid=0, in_ready=1, stall_cnt=0 immediately.
REQ-037 Saturation: CNT_W=4, out_ready=0 for 20 cycles while valid -> stall_cnt=15 and holding.
REQ-038 Parameter sweep: DATA_W=8, CTRL_W=0 and DATA_W=74, CTRL_W=5 -> random valid/ready traffic matches a scoreboard FIFO model.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// rtl/pipe_skid_reg_pkg.sv - shared occupancy encoding and EX/MEM payload layout
//
// Purpose: state encoding for the two-entry skid register and the bit layout
// of the EX/MEM bundle it carries by default (LSB first):
//   rd_addr[4:0], rs2_data[36:5], alu_result[68:37], reg_write[69],
//   mem_write[70], mem_read[71], mem_to_reg[73:72].
// The top five bits are the side-effect controls that must read as zero
// whenever the stage holds a bubble.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    localparam int EXMEM_W          = 74;
    localparam int EXMEM_CTRL_W     = 5;

    localparam int RD_ADDR_LSB      = 0;
    localparam int RD_ADDR_W        = 5;
    localparam int RS2_DATA_LSB     = 5;
    localparam int RS2_DATA_W       = 32;
    localparam int ALU_RESULT_LSB   = 37;
    localparam int ALU_RESULT_W     = 32;
    localparam int REG_WRITE_LSB    = 69;
    localparam int REG_WRITE_W      = 1;
    localparam int MEM_WRITE_LSB    = 70;
    localparam int MEM_WRITE_W      = 1;
    localparam int MEM_READ_LSB     = 71;
    localparam int MEM_READ_W       = 1;
    localparam int MEM_TO_REG_LSB   = 72;
    localparam int MEM_TO_REG_W     = 2;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register replacing the EX/MEM latch
//
// Purpose: registered-ready pipeline stage. Main entry drives out_data, the
// skid entry absorbs the one payload that can arrive while downstream stalls,
// so in_ready never depends combinationally on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous kill of all held entries (hazard unit)
//   in_valid   upstream payload valid
//   in_ready   stage can accept this cycle (registered)
//   in_data    upstream payload, DATA_W bits
//   out_valid  out_data valid (decoded from state)
//   out_ready  downstream accepts this cycle
//   out_data   payload to next stage, DATA_W bits
//   stall_cnt  saturating count of out_valid & ~out_ready cycles
module pipe_skid_reg #(
    parameter int DATA_W = 74,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_skid_reg_pkg::*;

    // Ones in the top CTRL_W bit positions; all-zero when CTRL_W is 0.
    localparam logic [DATA_W-1:0] CTRL_MASK = ~({DATA_W{1'b1}} >> CTRL_W);

    skid_state_t       r_state;
    skid_state_t       w_next_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_accept;
    logic              w_send;

    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = r_in_ready;
    assign out_data  = r_main;
    assign stall_cnt = r_stall_cnt;

    assign w_accept  = in_valid & r_in_ready;
    assign w_send    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            // Ready is a pure function of the next occupancy, hence registered.
            r_in_ready <= (w_next_state != ST_TWO);
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_send)      w_next_state = ST_TWO;
                    else if (!w_accept && w_send) w_next_state = ST_EMPTY;
                end
                ST_TWO:   if (w_send) w_next_state = ST_ONE;
                default:  w_next_state = ST_EMPTY;
            endcase
        end
    end

    // Whenever the stage goes empty the control bits of main are cleared so a
    // bubble can never trigger a memory or register-file side effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_main <= r_main & ~CTRL_MASK;
            r_skid <= r_skid & ~CTRL_MASK;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_main <= in_data;
                ST_ONE: begin
                    if (w_accept && w_send) r_main <= in_data;
                    else if (w_accept)      r_skid <= in_data;
                    else if (w_send)        r_main <= r_main & ~CTRL_MASK;
                end
                ST_TWO:   if (w_send) r_main <= r_skid;
                default:  ;
            endcase
        end
    end

    // Counts regardless of flush so the hazard unit sees true stall pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;

    localparam int AW   = 74;
    localparam int BW   = 8;
    localparam int ACNT = 16;
    localparam int BCNT = 4;
    localparam int AMAX = (1 << ACNT) - 1;
    localparam int BMAX = (1 << BCNT) - 1;
    localparam logic [AW-1:0] A_CTRL = {5'b11111, 69'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, flush_a, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [AW-1:0]   a_in_data, a_out_data;
    logic [ACNT-1:0] a_stall_cnt;

    logic            rst_b, flush_b, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [BW-1:0]   b_in_data, b_out_data;
    logic [BCNT-1:0] b_stall_cnt;

    pipe_skid_reg #(.DATA_W(AW), .CTRL_W(5), .CNT_W(ACNT)) u_a (
        .clk(clk), .rst(rst_a), .flush(flush_a),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall_cnt)
    );

    pipe_skid_reg #(.DATA_W(BW), .CTRL_W(0), .CNT_W(BCNT)) u_b (
        .clk(clk), .rst(rst_b), .flush(flush_b),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a bounded FIFO of capacity two plus a stall counter.
    logic [AW-1:0] qa[$];
    logic [BW-1:0] qb[$];
    int stall_a = 0;
    int stall_b = 0;

    function automatic logic [AW-1:0] rand_a();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[AW-1:0];
    endfunction

    task automatic drive_a(input logic v, input logic [AW-1:0] d, input logic r, input logic f);
        bit acc, snd;
        a_in_valid = v; a_in_data = d; a_out_ready = r; flush_a = f;
        acc = v && (qa.size() < 2);
        snd = (qa.size() > 0) && r;
        @(posedge clk);
        if (qa.size() > 0 && !r && stall_a < AMAX) stall_a++;
        if (f) qa.delete();
        else begin
            if (snd) qa.delete(0);
            if (acc) qa.push_back(d);
        end
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [BW-1:0] d, input logic r, input logic f);
        bit acc, snd;
        b_in_valid = v; b_in_data = d; b_out_ready = r; flush_b = f;
        acc = v && (qb.size() < 2);
        snd = (qb.size() > 0) && r;
        @(posedge clk);
        if (qb.size() > 0 && !r && stall_b < BMAX) stall_b++;
        if (f) qb.delete();
        else begin
            if (snd) qb.delete(0);
            if (acc) qb.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        flush_a = 0; flush_b = 0;
        a_in_valid = 1; a_in_data = '1; a_out_ready = 0;
        b_in_valid = 1; b_in_data = '1; b_out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_a_valid got %b want 0", a_out_valid); else n_pass++;
        n_checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_a_ready got %b want 1", a_in_ready); else n_pass++;
        n_checks++; if (a_stall_cnt !== '0) $display("FAIL reset_a_stall got %0d want 0", a_stall_cnt); else n_pass++;
        n_checks++; if (a_out_data !== '0) $display("FAIL reset_a_data got %h want 0", a_out_data); else n_pass++;
        n_checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) $display("FAIL reset_b_hs got v=%b r=%b want v=0 r=1", b_out_valid, b_in_ready); else n_pass++;
        n_checks++; if (b_out_data !== '0 || b_stall_cnt !== '0) $display("FAIL reset_b_state got d=%h s=%0d want 0 0", b_out_data, b_stall_cnt); else n_pass++;
        a_in_valid = 0; b_in_valid = 0;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        qa.delete(); qb.delete(); stall_a = 0; stall_b = 0;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 3; i++) begin
            drive_a(1'b1, AW'(i), 1'b1, 1'b0);
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== AW'(i)) $display("FAIL stream_out%0d got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, AW'(i)); else n_pass++;
            n_checks++; if (a_in_ready !== 1'b1) $display("FAIL stream_ready%0d got %b want 1", i, a_in_ready); else n_pass++;
        end
        drive_a(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b0 || (a_out_data & A_CTRL) !== '0) $display("FAIL stream_drain got v=%b d=%h want v=0 ctrl=0", a_out_valid, a_out_data); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] pa, pb;
        int base;
        pa = rand_a() | A_CTRL; pb = rand_a();
        base = stall_a;
        drive_a(1'b1, pa, 1'b0, 1'b0);
        n_checks++; if (a_out_data !== pa || a_in_ready !== 1'b1) $display("FAIL bp_one got d=%h r=%b want d=%h r=1", a_out_data, a_in_ready, pa); else n_pass++;
        drive_a(1'b1, pb, 1'b0, 1'b0);
        n_checks++; if (a_in_ready !== 1'b0 || a_out_data !== pa || a_out_valid !== 1'b1) $display("FAIL bp_two got r=%b v=%b d=%h want r=0 v=1 d=%h", a_in_ready, a_out_valid, a_out_data, pa); else n_pass++;
        drive_a(1'b1, ~pb, 1'b0, 1'b0);
        n_checks++; if (a_out_data !== pa || a_in_ready !== 1'b0) $display("FAIL bp_hold got d=%h r=%b want d=%h r=0", a_out_data, a_in_ready, pa); else n_pass++;
        n_checks++; if (a_stall_cnt !== ACNT'(base + 2)) $display("FAIL bp_stall got %0d want %0d", a_stall_cnt, base + 2); else n_pass++;
        drive_a(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (a_out_data !== pb || a_out_valid !== 1'b1 || a_in_ready !== 1'b1) $display("FAIL bp_second got v=%b r=%b d=%h want v=1 r=1 d=%h", a_out_valid, a_in_ready, a_out_data, pb); else n_pass++;
        drive_a(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b0 || a_stall_cnt !== ACNT'(base + 2)) $display("FAIL bp_end got v=%b s=%0d want v=0 s=%0d", a_out_valid, a_stall_cnt, base + 2); else n_pass++;
    endtask

    task automatic test_flush();
        logic [AW-1:0] pc;
        pc = rand_a() | A_CTRL;
        drive_a(1'b1, rand_a() | A_CTRL, 1'b0, 1'b0);
        drive_a(1'b1, rand_a() | A_CTRL, 1'b0, 1'b0);
        drive_a(1'b1, pc, 1'b0, 1'b1);
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("FAIL flush_hs got v=%b r=%b want v=0 r=1", a_out_valid, a_in_ready); else n_pass++;
        n_checks++; if ((a_out_data & A_CTRL) !== '0) $display("FAIL flush_ctrl got %h want ctrl bits 0", a_out_data); else n_pass++;
        n_checks++; if (a_stall_cnt !== ACNT'(stall_a)) $display("FAIL flush_stall got %0d want %0d", a_stall_cnt, stall_a); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, '0, 1'b1, 1'b0);
            n_checks++; if (a_out_valid !== 1'b0 || (a_out_data & A_CTRL) !== '0) $display("FAIL flush_gone%0d got v=%b d=%h want v=0 ctrl=0", i, a_out_valid, a_out_data); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [AW-1:0] px;
        drive_a(1'b1, rand_a(), 1'b0, 1'b0);
        drive_a(1'b1, rand_a(), 1'b0, 1'b0);
        drive_a(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_a = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("FAIL arst_hs got v=%b r=%b want v=0 r=1", a_out_valid, a_in_ready); else n_pass++;
        n_checks++; if (a_stall_cnt !== '0 || a_out_data !== '0) $display("FAIL arst_state got s=%0d d=%h want 0 0", a_stall_cnt, a_out_data); else n_pass++;
        qa.delete(); stall_a = 0;
        @(negedge clk);
        rst_a = 1'b0;
        px = rand_a();
        drive_a(1'b1, px, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== px) $display("FAIL arst_first got v=%b d=%h want v=1 d=%h", a_out_valid, a_out_data, px); else n_pass++;
        drive_a(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        int exp;
        drive_b(1'b1, 8'h5a, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            drive_b(1'b0, '0, 1'b0, 1'b0);
            exp = (i > 15) ? 15 : i;
            n_checks++; if (b_stall_cnt !== BCNT'(exp) || b_out_valid !== 1'b1) $display("FAIL sat_cyc%0d got s=%0d v=%b want s=%0d v=1", i, b_stall_cnt, b_out_valid, exp); else n_pass++;
        end
        // Bring B back to a clean state with an asynchronous reset.
        #2; rst_b = 1'b1; #1;
        qb.delete(); stall_b = 0;
        @(negedge clk); rst_b = 1'b0;
    endtask

    task automatic test_random_a();
        for (int n = 0; n < 400; n++) begin
            drive_a(1'($urandom_range(0, 2) != 0), rand_a(), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
            n_checks++; if (a_out_valid !== (qa.size() > 0) || a_in_ready !== (qa.size() < 2)) $display("FAIL rnda_hs@%0d got v=%b r=%b want depth %0d", n, a_out_valid, a_in_ready, qa.size()); else n_pass++;
            n_checks++; if (a_stall_cnt !== ACNT'(stall_a)) $display("FAIL rnda_stall@%0d got %0d want %0d", n, a_stall_cnt, stall_a); else n_pass++;
            if (qa.size() > 0) begin
                n_checks++; if (a_out_data !== qa[0]) $display("FAIL rnda_data@%0d got %h want %h", n, a_out_data, qa[0]); else n_pass++;
            end else begin
                n_checks++; if ((a_out_data & A_CTRL) !== '0 || $isunknown(a_out_data)) $display("FAIL rnda_bubble@%0d got %h want ctrl bits 0", n, a_out_data); else n_pass++;
            end
        end
    endtask

    task automatic test_random_b();
        for (int n = 0; n < 400; n++) begin
            drive_b(1'($urandom_range(0, 2) != 0), 8'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0));
            n_checks++; if (b_out_valid !== (qb.size() > 0) || b_in_ready !== (qb.size() < 2)) $display("FAIL rndb_hs@%0d got v=%b r=%b want depth %0d", n, b_out_valid, b_in_ready, qb.size()); else n_pass++;
            n_checks++; if (b_stall_cnt !== BCNT'(stall_b)) $display("FAIL rndb_stall@%0d got %0d want %0d", n, b_stall_cnt, stall_b); else n_pass++;
            if (qb.size() > 0) begin
                n_checks++; if (b_out_data !== qb[0]) $display("FAIL rndb_data@%0d got %h want %h", n, b_out_data, qb[0]); else n_pass++;
            end else begin
                n_checks++; if ($isunknown(b_out_data)) $display("FAIL rndb_bubble@%0d got %h want known", n, b_out_data); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random_a();
        test_random_b();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
